// File: rtl/acc_bank_if.sv
// Bus bundle for acc_bank: write command, read select and the read/flag results.
interface acc_bank_if #(
  parameter int WIDTH = 16,
  parameter int NACC  = 4
);
  localparam int SELW = $clog2(NACC);

  logic             ACCwrite;
  logic [1:0]       op;
  logic [SELW-1:0]  wrSel;
  logic [WIDTH-1:0] dataIn;
  logic [SELW-1:0]  rdSel;
  logic [WIDTH-1:0] dataOut;
  logic [3:0]       flags;

  modport master (output ACCwrite, op, wrSel, dataIn, rdSel, input dataOut, flags);
  modport slave  (input ACCwrite, op, wrSel, dataIn, rdSel, output dataOut, flags);
endinterface

// File: rtl/acc_bank.sv
// Bank of NACC accumulators with LOAD/ADD/SUB/CLR, optional signed saturation,
// a combinational read port and registered {zero, neg, carry, ovf} flags.
module acc_bank #(
  parameter int WIDTH = 16,
  parameter int NACC  = 4,
  parameter int SAT   = 0
) (
  input logic       clk,
  input logic       rst,
  acc_bank_if.slave bus
);
  localparam int SELW = $clog2(NACC);

  typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_ADD = 2'b01, OP_SUB = 2'b10, OP_CLR = 2'b11} op_e;

  logic [NACC-1:0][WIDTH-1:0] acc;
  logic [3:0]                 flags_q;
  logic [WIDTH-1:0]           cur, rd_val, res;
  logic [WIDTH:0]             sum, diff;
  logic                       hit, carry, ovf;

  // Fetch the destination channel; hit stays low for selects past NACC-1,
  // which turns the write into a no-op.
  always_comb begin
    cur = '0;
    hit = 1'b0;
    for (int i = 0; i < NACC; i++) begin
      if (bus.wrSel == SELW'(i)) begin
        cur = acc[i];
        hit = 1'b1;
      end
    end
  end

  // Read port: pre-write value during a write cycle, 0 for out-of-range selects.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NACC; i++) begin
      if (bus.rdSel == SELW'(i)) rd_val = acc[i];
    end
  end

  assign sum  = {1'b0, cur} + {1'b0, bus.dataIn};
  assign diff = {1'b0, cur} - {1'b0, bus.dataIn};

  // Operation result and arithmetic flags; saturation clamps toward the sign of
  // the current accumulator, which is the side that overflowed for both ADD and SUB.
  always_comb begin
    res   = cur;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op_e'(bus.op))
      OP_LOAD: res = bus.dataIn;
      OP_ADD: begin
        res   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (cur[WIDTH-1] == bus.dataIn[WIDTH-1]) && (sum[WIDTH-1] != cur[WIDTH-1]);
      end
      OP_SUB: begin
        res   = diff[WIDTH-1:0];
        carry = ~diff[WIDTH];
        ovf   = (cur[WIDTH-1] != bus.dataIn[WIDTH-1]) && (diff[WIDTH-1] != cur[WIDTH-1]);
      end
      OP_CLR: res = '0;
    endcase
    if ((SAT != 0) && ovf)
      res = cur[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

  // State update: reset wins over any write; only the selected channel changes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc     <= '0;
      flags_q <= 4'b0000;
    end else if (bus.ACCwrite && hit) begin
      for (int i = 0; i < NACC; i++) begin
        if (bus.wrSel == SELW'(i)) acc[i] <= res;
      end
      flags_q <= {res == '0, res[WIDTH-1], carry, ovf};
    end
  end

  assign bus.dataOut = rd_val;
  assign bus.flags   = flags_q;
endmodule

// File: tb/tb_acc_bank.sv
// Bench for acc_bank: three instances (wrap, saturating, NACC=3) driven in lockstep,
// checked against spec vectors and an integer reference model via a scoreboard.
module tb_acc_bank;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  acc_bank_if #(.WIDTH(16), .NACC(4)) ia();
  acc_bank_if #(.WIDTH(16), .NACC(4)) ib();
  acc_bank_if #(.WIDTH(16), .NACC(3)) ic();

  acc_bank #(.WIDTH(16), .NACC(4), .SAT(0)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  acc_bank #(.WIDTH(16), .NACC(4), .SAT(1)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
  acc_bank #(.WIDTH(16), .NACC(3), .SAT(0)) dut_c (.clk(clk), .rst(rst), .bus(ic.slave));

  localparam logic [1:0] LD = 2'b00, AD = 2'b01, SB = 2'b10, CL = 2'b11;

  int checks = 0;
  int errors = 0;

  // reference model state per instance
  logic [15:0] m_acc [3][4];
  logic [3:0]  m_fl  [3];
  int          m_sat [3] = '{0, 1, 0};
  int          m_n   [3] = '{4, 4, 3};
  bit          known = 1'b0;

  // currently applied stimulus
  logic        s_rst, s_w;
  logic [1:0]  s_op, s_sel, s_rsel;
  logic [15:0] s_din;

  typedef struct {
    logic [15:0] dout [3];
    logic [3:0]  fl   [3];
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        w;
    logic [1:0]  op, sel, rsel;
    logic [15:0] din;
    logic [15:0] pre_a, out_a, out_b;
    logic [3:0]  fl_a, fl_b;
  } vec_t;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] dout_of(input int d);
    case (d)
      0: return ia.dataOut;
      1: return ib.dataOut;
      default: return ic.dataOut;
    endcase
  endfunction

  function automatic logic [3:0] flags_of(input int d);
    case (d)
      0: return ia.flags;
      1: return ib.flags;
      default: return ic.flags;
    endcase
  endfunction

  function automatic logic [15:0] m_rd(input int d, input logic [1:0] rs);
    return (int'(rs) < m_n[d]) ? m_acc[d][rs] : 16'h0000;
  endfunction

  // integer-arithmetic model of one executed write
  task automatic model_write(input int d);
    int a, b, sa, sb_, u, s;
    logic [15:0] r;
    logic c, v;
    if (!s_w || int'(s_sel) >= m_n[d]) return;
    a = int'(m_acc[d][s_sel]); b = int'(s_din);
    sa = int'($signed(m_acc[d][s_sel])); sb_ = int'($signed(s_din));
    c = 1'b0; v = 1'b0; u = 0; s = 0;
    case (s_op)
      LD: r = s_din;
      AD: begin u = a + b; s = sa + sb_; c = (u > 65535); end
      SB: begin u = a - b; s = sa - sb_; c = (a >= b); end
      default: r = 16'h0000;
    endcase
    if (s_op == AD || s_op == SB) begin
      r = u[15:0];
      v = (s > 32767) || (s < -32768);
      if (m_sat[d] != 0 && v) r = (s > 0) ? 16'h7FFF : 16'h8000;
    end
    m_acc[d][s_sel] = r;
    m_fl[d] = {r == 16'h0000, r[15], c, v};
  endtask

  task automatic set_in(input logic r, input logic w, input logic [1:0] op,
                        input logic [1:0] sel, input logic [15:0] din, input logic [1:0] rsel);
    s_rst = r; s_w = w; s_op = op; s_sel = sel; s_din = din; s_rsel = rsel;
    rst = r;
    ia.ACCwrite = w; ib.ACCwrite = w; ic.ACCwrite = w;
    ia.op = op;      ib.op = op;      ic.op = op;
    ia.wrSel = sel;  ib.wrSel = sel;  ic.wrSel = sel;
    ia.dataIn = din; ib.dataIn = din; ic.dataIn = din;
    ia.rdSel = rsel; ib.rdSel = rsel; ic.rdSel = rsel;
  endtask

  // Check pre-edge read, advance model and push expectation, clock, pop and compare.
  task automatic step();
    exp_t e;
    #1;
    if (known)
      for (int d = 0; d < 3; d++) chk($sformatf("pre_dout[%0d]", d), dout_of(d), m_rd(d, s_rsel));
    for (int d = 0; d < 3; d++) begin
      if (!s_rst) begin
        for (int k = 0; k < 4; k++) m_acc[d][k] = 16'h0000;
        m_fl[d] = 4'b0000;
      end else begin
        model_write(d);
      end
      e.dout[d] = m_rd(d, s_rsel);
      e.fl[d]   = m_fl[d];
    end
    if (!s_rst) known = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (known) begin
      e = sb.pop_front();
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("dout[%0d]", d), dout_of(d), e.dout[d]);
        chk($sformatf("flags[%0d]", d), {12'h000, flags_of(d)}, {12'h000, e.fl[d]});
      end
    end else begin
      void'(sb.pop_front());
    end
  endtask

  vec_t tbl[17];

  initial begin
    tbl[0]  = '{1'b1, LD, 2'd2, 2'd2, 16'h1F00, 16'h0000, 16'h1F00, 16'h1F00, 4'b0000, 4'b0000};
    tbl[1]  = '{1'b1, AD, 2'd2, 2'd2, 16'h00FF, 16'h1F00, 16'h1FFF, 16'h1FFF, 4'b0000, 4'b0000};
    tbl[2]  = '{1'b0, LD, 2'd0, 2'd0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 4'b0000};
    tbl[3]  = '{1'b0, AD, 2'd1, 2'd1, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 4'b0000};
    tbl[4]  = '{1'b0, SB, 2'd3, 2'd3, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 4'b0000};
    tbl[5]  = '{1'b1, LD, 2'd0, 2'd0, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h7FFF, 4'b0000, 4'b0000};
    tbl[6]  = '{1'b1, AD, 2'd0, 2'd0, 16'h0001, 16'h7FFF, 16'h8000, 16'h7FFF, 4'b0101, 4'b0001};
    tbl[7]  = '{1'b1, SB, 2'd1, 2'd1, 16'h0001, 16'h0000, 16'hFFFF, 16'hFFFF, 4'b0100, 4'b0100};
    tbl[8]  = '{1'b0, LD, 2'd1, 2'd1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 4'b0100, 4'b0100};
    tbl[9]  = '{1'b1, LD, 2'd3, 2'd3, 16'h1234, 16'h0000, 16'h1234, 16'h1234, 4'b0000, 4'b0000};
    tbl[10] = '{1'b1, CL, 2'd3, 2'd3, 16'hFFFF, 16'h1234, 16'h0000, 16'h0000, 4'b1000, 4'b1000};
    tbl[11] = '{1'b1, LD, 2'd2, 2'd2, 16'hABCD, 16'h1FFF, 16'hABCD, 16'hABCD, 4'b0100, 4'b0100};
    tbl[12] = '{1'b1, SB, 2'd2, 2'd2, 16'h0BCD, 16'hABCD, 16'hA000, 16'hA000, 4'b0110, 4'b0110};
    tbl[13] = '{1'b1, AD, 2'd2, 2'd2, 16'h6000, 16'hA000, 16'h0000, 16'h0000, 4'b1010, 4'b1010};
    tbl[14] = '{1'b1, LD, 2'd0, 2'd0, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 4'b0100, 4'b0100};
    tbl[15] = '{1'b1, SB, 2'd0, 2'd0, 16'h0001, 16'h8000, 16'h7FFF, 16'h8000, 4'b0011, 4'b0111};
    tbl[16] = '{1'b1, AD, 2'd0, 2'd0, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h8000, 4'b0100, 4'b0111};

    set_in(1'b0, 1'b0, LD, 2'd0, 16'h0000, 2'd0);
    @(posedge clk); #1;

    // reset with a pending LOAD of all ones: everything reads zero
    set_in(1'b0, 1'b1, LD, 2'd0, 16'hFFFF, 2'd0);
    step();
    for (int k = 0; k < 4; k++) begin
      ia.rdSel = 2'(k); #1;
      chk("reset_ch", ia.dataOut, 16'h0000);
    end
    chk("reset_flags", {12'h000, ia.flags}, 16'h0000);

    // spec vector table
    for (int i = 0; i < 17; i++) begin
      set_in(1'b1, tbl[i].w, tbl[i].op, tbl[i].sel, tbl[i].din, tbl[i].rsel);
      #1;
      chk($sformatf("v%0d_pre_a", i), ia.dataOut, tbl[i].pre_a);
      step();
      chk($sformatf("v%0d_out_a", i), ia.dataOut, tbl[i].out_a);
      chk($sformatf("v%0d_out_b", i), ib.dataOut, tbl[i].out_b);
      chk($sformatf("v%0d_fl_a", i), {12'h000, ia.flags}, {12'h000, tbl[i].fl_a});
      chk($sformatf("v%0d_fl_b", i), {12'h000, ib.flags}, {12'h000, tbl[i].fl_b});
    end

    // untouched channels after the table: ch1 FFFF, ch3 0000 on the wrap instance
    ia.rdSel = 2'd1; #1; chk("ch1_keep", ia.dataOut, 16'hFFFF);
    ia.rdSel = 2'd3; #1; chk("ch3_keep", ia.dataOut, 16'h0000);

    // NACC=3: write to channel 3 ignored, read of channel 3 is zero, flags hold
    set_in(1'b1, 1'b1, LD, 2'd3, 16'h5A5A, 2'd3);
    step();
    chk("c_oob_read", ic.dataOut, 16'h0000);

    // reset beats a same-cycle write
    set_in(1'b0, 1'b1, AD, 2'd2, 16'h1111, 2'd2);
    step();
    chk("rst_prio", ia.dataOut, 16'h0000);
    chk("rst_prio_fl", {12'h000, ib.flags}, 16'h0000);

    // first edge with reset released accepts the write
    set_in(1'b1, 1'b1, LD, 2'd1, 16'h5555, 2'd1);
    step();
    chk("first_wr", ia.dataOut, 16'h5555);

    // back-to-back chain on one channel
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 1'b1, AD, 2'd1, 16'h1000, 2'd1);
      step();
    end
    chk("chain", ia.dataOut, 16'h9555);

    // random traffic against the model
    for (int i = 0; i < 300; i++) begin
      logic [15:0] din;
      case ($urandom_range(0, 3))
        0: din = 16'h7FFF;
        1: din = 16'h8000;
        2: din = 16'(($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0001);
        default: din = 16'($urandom());
      endcase
      set_in(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), din, 2'($urandom_range(0, 3)));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/acc_bank.md
ACC_BANK -- requirements
Module: acc_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning accumulator and data width in bits (>= 2).
REQ-002 SHALL have parameter NACC, default 4, meaning number of accumulator channels (>= 2).
REQ-003 SHALL have parameter SAT, default 0, meaning 0 = wrap-around arithmetic, 1 = signed saturating arithmetic.
REQ-004 SHALL have localparam SELW = clog2(NACC), meaning channel-select width.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port ACCwrite  input  1  write enable; the operation executes only when high.
REQ-008 SHALL have port op  input  2  operation: 00 LOAD, 01 ADD, 10 SUB, 11 CLR.
REQ-009 SHALL have port wrSel  input  SELW  destination channel.
REQ-010 SHALL have port dataIn  input  WIDTH  operand.
REQ-011 SHALL have port rdSel  input  SELW  read channel.
REQ-012 SHALL have port dataOut  output  WIDTH  value of channel rdSel.
REQ-013 SHALL have port flags  output  4  {zero, neg, carry, ovf} from the last executed write.

Function
REQ-014 SHALL hold NACC independent WIDTH-bit accumulator registers acc[0..NACC-1].
REQ-015 On a rising edge with rst high and ACCwrite high, acc[wrSel] SHALL take: LOAD dataIn; ADD acc+dataIn; SUB acc-dataIn; CLR 0.
REQ-016 With ACCwrite low, all accumulators and flags SHALL hold.
REQ-017 Channels other than wrSel SHALL never change on a write.
REQ-018 ADD/SUB SHALL be computed at WIDTH+1 bits; carry = bit WIDTH for ADD, carry = NOT borrow (acc >= dataIn unsigned) for SUB.
REQ-019 ovf SHALL be signed two's-complement overflow of the ADD/SUB; ovf and carry SHALL be 0 for LOAD and CLR.
REQ-020 With SAT=0 the result SHALL wrap modulo 2^WIDTH.
REQ-021 With SAT=1 and ovf=1 the result SHALL clamp to max positive (0111..1) if the operand signs predicted positive overflow, else to min negative (1000..0); ovf still reports 1.
REQ-022 zero and neg SHALL reflect the value actually written (after saturation): zero = result==0, neg = result MSB.
REQ-023 flags SHALL update only on executed writes, registered, valid from the cycle after the write edge.
REQ-024 dataOut SHALL be a combinational read of acc[rdSel]; when rdSel==wrSel during a write cycle it SHALL show the pre-write value, the new value from the next cycle.
REQ-025 If wrSel >= NACC (NACC not a power of two), the write SHALL be ignored, accumulators and flags unchanged.
REQ-026 If rdSel >= NACC, dataOut SHALL be 0.
REQ-027 Latency: one cycle from write edge to visible dataOut/flags; back-to-back writes to one channel every cycle SHALL chain correctly (each uses the previously written value).

Reset
REQ-028 When rst is low at a rising edge, all accumulators SHALL become 0 and flags SHALL become 4'b0000, regardless of ACCwrite/op.
REQ-029 Reset SHALL take priority over any write in the same cycle; a write aborted by reset leaves no effect.
REQ-030 Deasserting rst SHALL not modify state; the first write is accepted on the first edge with rst high.

Verification
REQ-031 Reset: rst=0 one edge with ACCwrite=1, op=LOAD, dataIn=0xFFFF -> all channels 0x0000, flags 0000.
REQ-032 Chaining: LOAD ch2 0x1F00, next cycle ADD ch2 0x00FF -> ch2=0x1FFF, ch0/1/3=0x0000, flags {0,0,0,0}.
REQ-033 Overflow: ch0=0x7FFF, ADD 0x0001 -> SAT=0: 0x8000, flags {0,1,0,1}; SAT=1: 0x7FFF, flags {0,0,0,1}.
REQ-034 Borrow: ch1=0x0000, SUB 0x0001 -> 0xFFFF, flags {0,1,0,0} for SAT=0 and SAT=1.
REQ-035 Hold/CLR: ACCwrite=0, dataIn=0xFFFF -> no channel or flag change; then CLR ch3 (holding 0x1234) -> ch3=0x0000, flags {1,0,0,0}.
REQ-036 Same-cycle read: rdSel=wrSel=2, LOAD 0xABCD over 0x1FFF -> dataOut 0x1FFF in write cycle, 0xABCD next cycle.
